// File: rtl/step_sched_pkg.sv
// ============================================================================
// step_sched_pkg: shared types and elaboration helpers for step_scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package step_sched_pkg;

   typedef enum logic [1:0] {
      PAUSED = 2'd0,
      WAIT   = 2'd1,
      REQ    = 2'd2
   } sched_state_t;

   // Cycles between ticks for rate index sel.
   function automatic int rate_period(input int in_freq, input int base, input int sel);
      return in_freq / (base << sel);
   endfunction

   function automatic int cnt_width(input int period0);
      return (period0 > 1) ? $clog2(period0) : 1;
   endfunction

   function automatic int sel_width(input int num_rates);
      return (num_rates > 1) ? $clog2(num_rates) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rate_tick.sv
// ============================================================================
// rate_tick: programmable-period tick generator (clock-enable divider)
// Rev 1.0
// ============================================================================
`default_nettype none

module rate_tick
   import step_sched_pkg::*;
#(
   parameter int IN_FREQUENCY = 10**7,
   parameter int BASE_RATE    = 1,
   parameter int NUM_RATES    = 8,
   parameter int SEL_W        = 3
) (
   input  logic             inclk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [SEL_W-1:0] rate_sel,
   output logic             tick
);

   localparam int CNT_W   = cnt_width(rate_period(IN_FREQUENCY, BASE_RATE, 0));
   localparam int NUM_SEL = 1 << SEL_W;

   if (rate_period(IN_FREQUENCY, BASE_RATE, NUM_RATES - 1) < 2) begin : g_period_check
      $error("rate_tick: fastest rate period is below 2 cycles");
   end

   // Indices past the last rate reuse the last rate, so clamping costs no compare.
   logic [CNT_W-1:0] last_tbl [NUM_SEL];

   for (genvar i = 0; i < NUM_SEL; i++) begin : g_period
      localparam int IDX = (i < NUM_RATES) ? i : NUM_RATES - 1;
      assign last_tbl[i] = CNT_W'(rate_period(IN_FREQUENCY, BASE_RATE, IDX) - 1);
   end

   logic [SEL_W-1:0] sel_q;
   logic             loaded;
   logic [CNT_W-1:0] cnt;
   logic             changed;
   logic             at_last;

   assign changed = loaded && (sel_q != rate_sel);
   assign at_last = (cnt == last_tbl[rate_sel]);
   assign tick    = en && !changed && at_last;

   always_ff @(posedge inclk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q  <= '0;
         loaded <= 1'b0;
         cnt    <= '0;
      end else begin
         sel_q  <= rate_sel;
         loaded <= 1'b1;
         if (!en || changed || at_last) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/step_scheduler.sv
// ============================================================================
// step_scheduler: rate-driven generation-step requester with req/ack handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module step_scheduler
   import step_sched_pkg::*;
#(
   parameter int IN_FREQUENCY = 10**7,
   parameter int BASE_RATE    = 1,
   parameter int NUM_RATES    = 8,
   parameter int GEN_WIDTH    = 32
) (
   input  logic                            inclk,
   input  logic                            rst_n,
   input  logic                            run,
   input  logic                            step_btn,
   input  logic [sel_width(NUM_RATES)-1:0] rate_sel,
   output logic                            step_req,
   input  logic                            step_ack,
   output logic                            busy,
   output logic                            overrun,
   input  logic                            clr_overrun,
   output logic [GEN_WIDTH-1:0]            gen_count
);

   localparam int SEL_W = sel_width(NUM_RATES);

   sched_state_t state;
   sched_state_t state_nx;
   logic         tick;
   logic         en;
   logic         done;

   // Counting starts the edge after leaving PAUSED, so the first tick lands P cycles later.
   assign en   = run && (state != PAUSED);
   assign done = (state == REQ) && step_ack;

   rate_tick #(
      .IN_FREQUENCY (IN_FREQUENCY),
      .BASE_RATE    (BASE_RATE),
      .NUM_RATES    (NUM_RATES),
      .SEL_W        (SEL_W)
   ) u_rate_tick (
      .inclk    (inclk),
      .rst_n    (rst_n),
      .en       (en),
      .rate_sel (rate_sel),
      .tick     (tick)
   );

   always_comb begin
      state_nx = state;
      case (state)
         PAUSED: begin
            if (run)           state_nx = WAIT;
            else if (step_btn) state_nx = REQ;
         end
         WAIT: begin
            if (!run)          state_nx = PAUSED;
            else if (tick)     state_nx = REQ;
         end
         REQ: begin
            if (step_ack)      state_nx = run ? WAIT : PAUSED;
         end
         default:              state_nx = PAUSED;
      endcase
   end

   always_ff @(posedge inclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= PAUSED;
         step_req  <= 1'b0;
         overrun   <= 1'b0;
         gen_count <= '0;
      end else begin
         state    <= state_nx;
         step_req <= (state_nx == REQ);
         if (done) begin
            gen_count <= gen_count + GEN_WIDTH'(1);
         end
         // A tick meeting an outstanding step is dropped; setting beats clearing.
         if ((state == REQ) && tick) begin
            overrun <= 1'b1;
         end else if (clr_overrun) begin
            overrun <= 1'b0;
         end
      end
   end

   assign busy = step_req;

endmodule

`default_nettype wire
